stream_frame_ctrl: RTL

Frame controller for the serial byte-stream datapath. It hunts a bit-aligned sync word in the 1-bit input stream and locks byte boundaries to it. It then splits each frame into header and payload bytes, using the length carried in header byte 0, and sequences frame start, end and abort. Assembled bytes leave through a small tagged FIFO with a valid/ready handshake to downstream consumers.

---
 rtl/stream_frame_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/stream_frame_ctrl.sv
// Serial frame controller: bit-aligned sync hunt, header/payload byte assembly
// driven by the length in header byte 0, and a tagged first-word-fall-through output FIFO.
module stream_frame_ctrl #(
  parameter logic [7:0]  SYNC_WORD  = 8'hA5,
  parameter int unsigned HDR_BYTES  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stream,
  input  logic       en,
  output logic [7:0] data_out,
  output logic       data_sel,
  output logic       data_last,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       sync_lock,
  output logic       frame_abort,
  output logic       ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD} state_t;

  typedef struct packed {
    logic       last;
    logic       sel;
    logic [7:0] data;
  } entry_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d, shift_in;
  logic [3:0]    hunt_cnt_q, hunt_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    len_q, len_d, hdr_len;
  logic          push_req;
  entry_t        push_entry;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, pop, overflow, push_ok;
  logic          ovf_q, abort_q;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = data_valid && data_ready;
  assign overflow = push_req && full && !pop;
  assign push_ok  = push_req && !overflow;
  assign shift_in = {stream, shift_q[7:1]};

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hunt_cnt_d = hunt_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    hdr_len    = len_q;
    push_req   = 1'b0;
    push_entry = '0;

    if (en) begin
      shift_d = shift_in;
      unique case (state_q)
        HUNT: begin
          hunt_cnt_d = (hunt_cnt_q == 4'd8) ? 4'd8 : hunt_cnt_q + 4'd1;
          if (hunt_cnt_d == 4'd8 && shift_in == SYNC_WORD) begin
            state_d    = HEADER;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
          end
        end
        HEADER: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push_req        = 1'b1;
            push_entry.data = shift_in;
            // Byte 0 carries the payload length; it is usable in the same cycle it completes.
            if (byte_cnt_q == 8'd0) begin
              len_d   = shift_in;
              hdr_len = shift_in;
            end
            if (byte_cnt_q == 8'(HDR_BYTES - 1)) begin
              byte_cnt_d = 8'd0;
              if (hdr_len == 8'd0) begin
                push_entry.last = 1'b1;
                state_d         = HUNT;
              end else begin
                state_d = PAYLOAD;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
        PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push_req        = 1'b1;
            push_entry.sel  = 1'b1;
            push_entry.data = shift_in;
            byte_cnt_d      = byte_cnt_q + 8'd1;
            if (byte_cnt_q == len_q - 8'd1) begin
              push_entry.last = 1'b1;
              state_d         = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // A dropped byte kills the frame; the hunt restarts with a fresh 8-bit window.
    if (push_req && full && !pop) state_d = HUNT;
    if (state_d == HUNT && state_q != HUNT) hunt_cnt_d = 4'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      shift_q    <= 8'd0;
      hunt_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      len_q      <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hunt_cnt_q <= hunt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (overflow) ovf_q <= 1'b1;
      abort_q <= overflow;
    end
  end

  // NOTE: FIFO storage is not reset; data_valid (from the reset count) decides whether it is looked at.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_entry;
  end

  entry_t head;
  assign head        = mem[rd_ptr_q];
  assign data_valid  = (count_q != '0);
  assign data_out    = data_valid ? head.data : 8'h00;
  assign data_sel    = data_valid & head.sel;
  assign data_last   = data_valid & head.last;
  assign sync_lock   = (state_q == HEADER) || (state_q == PAYLOAD);
  assign frame_abort = abort_q;
  assign ovf         = ovf_q;

endmodule
